// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles 32-bit little-endian words from an 8-bit shared memory port.
// Optional misaligned-redirect trap is enabled by defining INST_FETCH_MISALIGN_CHECK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_busy_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] mem_a_o,
    output logic        mem_req_o,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_addr_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        fetch_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] inst_q, inst_d;
    logic        cap_q, cap_d;
    logic [1:0]  cap_idx_q, cap_idx_d;
    logic        req;

    // idx counts requested bytes; idx==4 is the wait cycle for the last byte's data.
    always_comb begin
        req = (state_q == S_FETCH) && !mem_busy_i && !idx_q[2];
        mem_req_o = req;
        mem_a_o   = req ? (pc_q + {30'b0, idx_q[1:0]}) : pc_q;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        idx_d     = idx_q;
        inst_d    = inst_q;
        cap_d     = 1'b0;
        cap_idx_d = cap_idx_q;

        // Data returns one cycle after its request, independent of this cycle's busy.
        if (cap_q) begin
            case (cap_idx_q)
                2'd0:    inst_d[7:0]   = mem_din_i;
                2'd1:    inst_d[15:8]  = mem_din_i;
                2'd2:    inst_d[23:16] = mem_din_i;
                default: inst_d[31:24] = mem_din_i;
            endcase
        end

        if (req) begin
            cap_d     = 1'b1;
            cap_idx_d = idx_q[1:0];
            idx_d     = idx_q + 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                idx_d   = '0;
            end
            S_FETCH: begin
                if (idx_q[2]) begin
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (!stall_i) begin
                    pc_d    = pc_q + 32'd4;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect overrides everything above, including an in-flight byte.
        if (branch_flag_i) begin
            idx_d = '0;
            cap_d = 1'b0;
`ifdef INST_FETCH_MISALIGN_CHECK_EN
            pc_d = branch_target_addr_i;
            if (branch_target_addr_i[1:0] != 2'b00) begin
                state_d = S_ERR;
            end else begin
                state_d = S_FETCH;
            end
`else
            pc_d    = branch_target_addr_i & ~32'h0000_0003;
            state_d = S_FETCH;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            idx_q     <= '0;
            inst_q    <= '0;
            cap_q     <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            idx_q     <= idx_d;
            inst_q    <= inst_d;
            cap_q     <= cap_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = (state_q == S_VALID);
`ifdef INST_FETCH_MISALIGN_CHECK_EN
    assign fetch_err_o  = (state_q == S_ERR);
`else
    assign fetch_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a byte memory model; honours INST_FETCH_MISALIGN_CHECK_EN.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_busy_i;
    logic [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic        mem_req_o;
    logic        branch_flag_i;
    logic [31:0] branch_target_addr_i;
    logic        stall_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_err_o;

    logic [7:0]  mem [0:8191];
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .mem_busy_i(mem_busy_i), .mem_din_i(mem_din_i),
        .mem_a_o(mem_a_o), .mem_req_o(mem_req_o), .branch_flag_i(branch_flag_i),
        .branch_target_addr_i(branch_target_addr_i), .stall_i(stall_i),
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o), .fetch_err_o(fetch_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic br, input logic [31:0] tgt,
                         input logic st, input logic busy);
        rst = r; branch_flag_i = br; branch_target_addr_i = tgt;
        stall_i = st; mem_busy_i = busy;
        #1;
    endtask

    // One clock: the memory answers a request on the following cycle.
    task automatic tick();
        logic        req;
        logic [31:0] a;
        #1;
        req = mem_req_o;
        a   = mem_a_o;
        @(posedge clk);
        #1;
        mem_din_i = req ? mem[a[12:0]] : 8'hEE;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
        chk({tag, "_req"},   {31'b0, mem_req_o},    32'd0);
        chk({tag, "_pc"},    pc_o,                  32'h0000_0000);
        chk({tag, "_inst"},  inst_o,                32'h0000_0000);
        chk({tag, "_err"},   {31'b0, fetch_err_o},  32'd0);
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"},  {31'b0, mem_req_o}, 32'd1);
        chk({tag, "_addr"}, mem_a_o,            addr);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] pc, input logic [31:0] word);
        chk({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd1);
        chk({tag, "_inst"},  inst_o,                word);
        chk({tag, "_pc"},    pc_o,                  pc);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        {mem[0], mem[1], mem[2], mem[3]}                 = {8'h13, 8'h05, 8'h10, 8'h00};
        {mem[4], mem[5], mem[6], mem[7]}                 = {8'h93, 8'h05, 8'h20, 8'h00};
        {mem[13'h1000], mem[13'h1001], mem[13'h1002], mem[13'h1003]} = {8'hB7, 8'h12, 8'h34, 8'h56};
        {mem[13'h1004], mem[13'h1005], mem[13'h1006], mem[13'h1007]} = {8'h11, 8'h22, 8'h33, 8'h44};
        {mem[13'h0100], mem[13'h0101], mem[13'h0102], mem[13'h0103]} = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        {mem[13'h1FFC], mem[13'h1FFD], mem[13'h1FFE], mem[13'h1FFF]} = {8'h01, 8'h02, 8'h03, 8'h04};
        mem_din_i = 8'h00;

        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(); tick();
        chk_reset_outputs("reset");

        // Cycle 0 IDLE, cycles 1-4 byte requests, cycle 6 word valid
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("idle_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_req("w0", 32'(i));
            tick();
        end
        chk("w0_c5_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("w0_c5_req",   {31'b0, mem_req_o},    32'd0);
        tick();
        chk_word("w0", 32'h0, 32'h0010_0513);
        tick();

        // Next word at 4, then stall 3 cycles in VALID
        for (int i = 0; i < 4; i++) begin
            chk_req("w1", 32'(4 + i));
            tick();
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_word("stall", 32'h4, 32'h0020_0593);
            chk("stall_req", {31'b0, mem_req_o}, 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("stall_release_valid", {31'b0, inst_valid_o}, 32'd1);
        tick();
        chk_req("after_stall", 32'h8);
        tick();
        chk_req("w2_b1", 32'h9);
        tick();

        // Redirect at idx=2
        chk_req("w2_b2", 32'hA);
        drive(1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("br_valid", {31'b0, inst_valid_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk_req("br", 32'h1000 + 32'(i));
            tick();
        end
        tick();
        chk_word("br", 32'h1000, 32'h5634_12B7);
        tick();

        // Busy for two cycles after the byte 1 request
        chk_req("busy_b0", 32'h1004);
        tick();
        chk_req("busy_b1", 32'h1005);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("busy1_req",  {31'b0, mem_req_o}, 32'd0);
        chk("busy1_addr", mem_a_o, 32'h1004);
        tick();
        chk("busy2_req",  {31'b0, mem_req_o}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_req("busy_b2", 32'h1006);
        tick();
        chk_req("busy_b3", 32'h1007);
        tick();
        chk("busy_unbusy_slot_valid", {31'b0, inst_valid_o}, 32'd0);
        tick();
        chk_word("busy", 32'h1004, 32'h4433_2211);
        tick();

        // Misaligned redirect
        chk_req("mis_pre", 32'h1008);
        drive(1'b0, 1'b1, 32'h0000_0102, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifdef INST_FETCH_MISALIGN_CHECK_EN
        chk("err_flag",  {31'b0, fetch_err_o},  32'd1);
        chk("err_req",   {31'b0, mem_req_o},    32'd0);
        chk("err_pc",    pc_o,                  32'h0000_0102);
        chk("err_valid", {31'b0, inst_valid_o}, 32'd0);
        tick();
        chk("err_hold_flag", {31'b0, fetch_err_o}, 32'd1);
        chk("err_hold_req",  {31'b0, mem_req_o},   32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        chk("err_exit_flag", {31'b0, fetch_err_o}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`endif
        chk("mis_err_clear", {31'b0, fetch_err_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk_req("mis", 32'h100 + 32'(i));
            tick();
        end
        tick();
        chk_word("mis", 32'h100, 32'hDEAD_BEEF);
        tick();

        // Reset with simultaneous redirect at idx=3
        for (int i = 0; i < 3; i++) begin
            chk_req("rst_pre", 32'h104 + 32'(i));
            tick();
        end
        chk_req("rst_idx3", 32'h107);
        drive(1'b1, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_reset_outputs("midreset");
        tick();
        chk_req("restart", 32'h0);

        // PC wrap at the top of the address space
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_req("wrap", 32'hFFFF_FFFC + 32'(i));
            tick();
        end
        tick();
        chk_word("wrap", 32'hFFFF_FFFC, 32'h0403_0201);
        tick();
        chk_req("wrap_next", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_busy_i  input  1  byte memory port owned by another requester this cycle.
REQ-005 SHALL have port mem_din_i  input  8  read data byte, valid the cycle after a request.
REQ-006 SHALL have port mem_a_o  output  32  byte read address.
REQ-007 SHALL have port mem_req_o  output  1  read request this cycle.
REQ-008 SHALL have port branch_flag_i  input  1  redirect request from decode.
REQ-009 SHALL have port branch_target_addr_i  input  32  redirect PC.
REQ-010 SHALL have port stall_i  input  1  decode cannot accept an instruction this cycle.
REQ-011 SHALL have port pc_o  output  32  PC of inst_o.
REQ-012 SHALL have port inst_o  output  32  assembled instruction word.
REQ-013 SHALL have port inst_valid_o  output  1  pc_o/inst_o valid, consumed when stall_i=0.
REQ-014 SHALL have port fetch_err_o  output  1  misaligned redirect trapped (see Configuration).

Function
REQ-015 SHALL implement states IDLE, FETCH, VALID, ERR; reset to IDLE.
REQ-016 SHALL: IDLE -> FETCH the cycle after reset deasserts, byte index cleared.
REQ-017 SHALL, in FETCH with mem_busy_i=0, drive mem_req_o=1, mem_a_o=pc+idx (idx 0..3), then idx+1; with mem_busy_i=1, drive mem_req_o=0 and hold idx.
REQ-018 SHALL capture mem_din_i into inst byte k (bits 8k+7:8k, little-endian) exactly one cycle after the request for byte k, regardless of mem_busy_i in the capture cycle.
REQ-019 SHALL enter VALID the cycle after byte 3 is captured; unbusy latency from FETCH entry to inst_valid_o=1 is 5 cycles.
REQ-020 SHALL, in VALID, hold inst_valid_o=1 with stable pc_o/inst_o while stall_i=1; when stall_i=0 the word is consumed, pc <= pc+4, next cycle FETCH with idx=0, inst_valid_o=0.
REQ-021 SHALL give branch_flag_i priority over stall_i and mem_busy_i in every state except reset: next cycle pc <= target, idx=0, in-flight byte discarded, inst_valid_o=0, state FETCH.
REQ-022 SHALL drive mem_req_o=0 in IDLE, VALID, ERR.
REQ-023 SHALL wrap PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-024 SHALL drive mem_a_o=pc when mem_req_o=0.

Reset
REQ-025 SHALL on rst=1 at a clock edge set state IDLE, pc=RESET_PC, idx=0, inst_o=0, pc_o=RESET_PC, inst_valid_o=0, mem_req_o=0, fetch_err_o=0; pending capture discarded.
REQ-026 SHALL give rst priority over branch_flag_i, stall_i, mem_busy_i, including mid-fetch.

Configuration
REQ-027 SHALL use macro INST_FETCH_MISALIGN_CHECK_EN.
REQ-028 SHALL, when defined, on redirect with target[1:0]!=0 go to ERR: fetch_err_o=1, pc_o=target, no requests; leave only by aligned redirect (-> FETCH, fetch_err_o=0) or reset.
REQ-029 SHALL, when undefined, clear target[1:0] on redirect, never enter ERR, tie fetch_err_o=0.

Verification
REQ-030 SHALL cover: reset, memory bytes 0x13,0x05,0x10,0x00 at 0..3, stall_i=0 -> mem_a_o 0,1,2,3 on cycles 1-4, inst_valid_o=1 cycle 6 with inst_o=32'h0010_0513, pc_o=0, next request at address 4.
REQ-031 SHALL cover: stall_i=1 for 3 cycles in VALID -> inst_o/pc_o constant, mem_req_o=0; fetch of pc+4 starts the cycle after stall_i falls.
REQ-032 SHALL cover: branch_flag_i=1, target 32'h0000_1000 at idx=2 -> next cycle mem_a_o=32'h1000, earlier bytes dropped, word at 0x1000 delivered with pc_o=32'h1000.
REQ-033 SHALL cover: mem_busy_i=1 for 2 cycles after byte 1 request -> byte 1 still captured, idx held, inst_valid_o delayed exactly 2 cycles, inst_o correct.
REQ-034 SHALL cover: branch target 32'h0000_0102 -> with macro fetch_err_o=1, no requests until aligned redirect; without macro fetch resumes at 32'h0000_0100.
REQ-035 SHALL cover: rst=1 at idx=3 with branch_flag_i=1 same cycle -> outputs at reset values, fetch restarts at RESET_PC.
